// File: rtl/sample_accum_pkg.sv
// rtl/sample_accum_pkg.sv - shared defaults for the sample accumulator slice
package sample_accum_pkg;

    localparam int DTI_W_DATA_DEFAULT = 8;

endpackage

// File: rtl/sample_accum_if.sv
// rtl/sample_accum_if.sv - dti valid/ready stream interface with producer/consumer views
interface dti
    import sample_accum_pkg::*;
#(
    parameter int W_DATA = DTI_W_DATA_DEFAULT
) ();

    logic [W_DATA-1:0] data;
    logic              valid;
    logic              ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);

endinterface

// File: rtl/sample_accum.sv
// rtl/sample_accum.sv - accumulates RATIO accepted beats, emits the shifted window sum
module sample_accum
    import sample_accum_pkg::*;
#(
    parameter int RATIO  = 4,
    parameter int SHIFT  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    dti.consumer  din,
    dti.producer  dout
);

    localparam int W_DATA = $bits(din.data);
    localparam int W_ACC  = W_DATA + $clog2(RATIO);
    localparam int W_CNT  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(RATIO - 1);

    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic [W_ACC-1:0]  acc_q, acc_d;
    logic [W_DATA-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [W_ACC-1:0]  sum;
    logic [W_ACC-1:0]  scaled;
    logic              in_hs, out_hs, final_beat;

    function automatic logic [W_ACC-1:0] ext(input logic [W_DATA-1:0] d);
        logic signed [W_ACC-1:0] s;
        logic        [W_ACC-1:0] u;
        s = W_ACC'($signed(d));
        u = W_ACC'(d);
        return SIGNED ? s : u;
    endfunction

    // The final beat may only enter when the output slot is empty or draining now.
    assign final_beat = (cnt_q == CNT_LAST);
    assign din.ready  = !final_beat || !out_valid_q || dout.ready;
    assign in_hs      = din.valid && din.ready;
    assign out_hs     = out_valid_q && dout.ready;

    assign sum    = acc_q + ext(din.data);
    assign scaled = SIGNED ? W_ACC'($signed(sum) >>> SHIFT) : (sum >> SHIFT);

    assign dout.data  = out_data_q;
    assign dout.valid = out_valid_q;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_hs) begin
            out_valid_d = 1'b0;
        end
        // A result load overrides the drain so results stream without a bubble.
        if (in_hs) begin
            if (final_beat) begin
                out_data_d  = scaled[W_DATA-1:0];
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/sample_accum.md
Name: sample_accum

Overview:
Downstream neighbour of the sample stage. It consumes a dti stream of samples and accumulates RATIO consecutive accepted beats. It then emits one scaled result per window: the sum arithmetically right-shifted by SHIFT, so SHIFT = log2(RATIO) gives the mean. The output is registered with dti valid/ready backpressure, and it sustains one input per cycle while dout.ready stays high.

Parameters:
RATIO, 4, beats per window; legal range is 1 and above.
SHIFT, 2, right shift applied to the window sum before output; legal range is 0 to W_ACC-1.
SIGNED, 0, 1 = two's-complement data (arithmetic shift, sign-extended add); 0 = unsigned.
W_DATA, derived from $size(din.data), not user-set; input/output data width.
W_ACC, derived as W_DATA + $clog2(RATIO) (W_DATA when RATIO = 1); accumulator width, cannot overflow.

Ports:
clk  input  1  clock; all logic is on posedge clk.
rst  input  1  reset, synchronous, active-high.
din  dti.consumer  W_DATA data + valid/ready  sample stream in.
dout  dti.producer  W_DATA data + valid/ready  one result per RATIO accepted inputs.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- State:
  - cnt: 0..RATIO-1, the position within the window.
  - acc: W_ACC bits, the partial sum.
  - out_data / out_valid: the output register, driving dout.data / dout.valid.
- Reset values: cnt=0, acc=0, out_valid=0 (so dout.valid=0), out_data=0.
- Reset mid-window discards the partial sum. Reset with out_valid=1 drops the pending result; no handshake occurs.
- Output handshake (out_hs): dout.valid && dout.ready.
- Input handshake (in_hs): din.valid && din.ready.
- Ready rule: din.ready = (cnt != RATIO-1) || !out_valid || dout.ready.
  - Non-final beats are always accepted.
  - The final beat is accepted only if the output slot is free or drains in the same cycle.
  - din.ready does not depend on din.valid.
- Extension: din.data is extended to W_ACC, sign-extended if SIGNED, else zero-extended.
- in_hs with cnt < RATIO-1: acc <= acc + ext(din.data); cnt <= cnt+1.
- in_hs with cnt == RATIO-1 (final beat):
  - sum = acc + ext(din.data);
  - out_data <= low W_DATA bits of (sum >> SHIFT), arithmetic shift if SIGNED;
  - out_valid <= 1; acc <= 0; cnt <= 0.
- No in_hs: acc and cnt hold.
- out_valid clears on out_hs, unless a final beat loads a new result in the same cycle. Load wins, so back-to-back results stream with no bubble.
- out_data and out_valid are stable while out_valid=1 and dout.ready=0.
- Latency: the result is visible on dout the cycle after the final-beat in_hs.
- RATIO=1: cnt stays 0 and every beat is final. The block behaves as a one-entry pipeline register with shift, at full throughput.
- Truncation: results wider than W_DATA after the shift are truncated, not saturated. With SHIFT = log2(RATIO) the mean always fits.
- No explicit FSM. The counter is the state: ACCUM for cnt < RATIO-1, FINAL for cnt = RATIO-1.

Decomposition:
- No new shared-package entries; W_ACC and the extension function are local to the module.
- Single module, no sub-module. The output register is the standard dti register stage and stays inline, since its load condition is coupled to cnt.

Test Plan:
- Mean, unsigned: W_DATA=8, RATIO=4, SHIFT=2, SIGNED=0, dout.ready=1; inputs 1,2,3,6 on consecutive cycles -> a single dout beat 3, one cycle after the 6 is accepted; din.ready stays 1 throughout.
- Backpressure: result 3 pending with dout.ready=0; next inputs 4,4,4,4 -> first three accepted, then din.ready=0 with cnt=3. Raise dout.ready -> 3 handshakes, the fourth 4 is accepted the same cycle, next dout=4 with no bubble.
- Signed rounding: SIGNED=1; inputs -4,-4,-4,-3 (sum -15) -> dout=0xFC (-4, arithmetic floor).
- Reset mid-window: accept 10,10, assert rst for 1 cycle, then feed 1,1,1,1 -> exactly one dout beat, value 1; dout.valid is 0 during and after reset until the window completes.
- Full scale, no overflow: inputs 255,255,255,255 unsigned -> dout=255 (acc 1020 fits 10 bits).
- Pass-through: RATIO=1, SHIFT=0, inputs 5,6,7 back-to-back, ready held high -> dout 5,6,7 on consecutive cycles, each 1 cycle late. Then hold dout.ready=0 -> din.ready=0 while out_valid=1.
